// File: rtl/axis_insert_header_arb.sv
// axis_insert_header_arb: round-robin arbiter/sequencer sharing one header inserter among NUM_SRC sources.
// Latency: grant one cycle after a request is seen in IDLE; header and payload pass through combinationally.
// Backpressure: only the granted source sees the inserter's ready, and only on the channel of the current phase.
// Optional build macro AXIS_HDR_ARB_STRICT_PRIO_EN selects lowest-index-wins arbitration instead of round-robin.
module axis_insert_header_arb #(
  parameter int NUM_SRC      = 4,
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
  parameter int SRC_WD       = $clog2(NUM_SRC)
) (
  input  logic                            clk,
  input  logic                            rstn,
  // per-source payload channels
  input  logic [NUM_SRC-1:0]              s_valid_in,
  input  logic [NUM_SRC*DATA_WD-1:0]      s_data_in,
  input  logic [NUM_SRC*DATA_BYTE_WD-1:0] s_keep_in,
  input  logic [NUM_SRC-1:0]              s_last_in,
  output logic [NUM_SRC-1:0]              s_ready_in,
  // per-source header channels
  input  logic [NUM_SRC-1:0]              s_valid_insert,
  input  logic [NUM_SRC*DATA_WD-1:0]      s_data_insert,
  input  logic [NUM_SRC*DATA_BYTE_WD-1:0] s_keep_insert,
  input  logic [NUM_SRC*BYTE_CNT_WD-1:0]  s_byte_insert_cnt,
  output logic [NUM_SRC-1:0]              s_ready_insert,
  // shared payload channel towards the inserter
  output logic                            m_valid_in,
  output logic [DATA_WD-1:0]              m_data_in,
  output logic [DATA_BYTE_WD-1:0]         m_keep_in,
  output logic                            m_last_in,
  input  logic                            m_ready_in,
  // shared header channel towards the inserter
  output logic                            m_valid_insert,
  output logic [DATA_WD-1:0]              m_data_insert,
  output logic [DATA_BYTE_WD-1:0]         m_keep_insert,
  output logic [BYTE_CNT_WD-1:0]          m_byte_insert_cnt,
  input  logic                            m_ready_insert,
  // status
  output logic [SRC_WD-1:0]               grant_id,
  output logic                            busy,
  output logic                            pkt_done
);

  typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;

  state_t            state;
  logic [SRC_WD-1:0] rr_ptr;
  logic [SRC_WD-1:0] winner;
  logic [SRC_WD-1:0] next_ptr;
  logic              any_req;
  logic              hdr_fire;
  logic              last_fire;

  assign any_req   = |s_valid_insert;
  assign hdr_fire  = m_valid_insert && m_ready_insert;
  assign last_fire = m_valid_in && m_ready_in && m_last_in;
  assign busy      = (state != IDLE);
  assign next_ptr  = (grant_id == SRC_WD'(NUM_SRC - 1)) ? '0 : grant_id + 1'b1;

`ifdef AXIS_HDR_ARB_STRICT_PRIO_EN
  // Pick the lowest-index requester; scanning downwards lets the lowest index overwrite the rest.
  always_comb begin
    winner = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (s_valid_insert[k]) winner = SRC_WD'(k);
    end
  end
`else
  // Pick the first requester at or after rr_ptr, wrapping; the smallest offset wins.
  always_comb begin
    int idx;
    winner = '0;
    idx    = 0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (s_valid_insert[idx]) winner = SRC_WD'(idx);
    end
  end
`endif

  // Route the granted source's channel for the current phase; everything else stays quiet and zero.
  always_comb begin
    s_ready_in        = '0;
    s_ready_insert    = '0;
    m_valid_in        = 1'b0;
    m_data_in         = '0;
    m_keep_in         = '0;
    m_last_in         = 1'b0;
    m_valid_insert    = 1'b0;
    m_data_insert     = '0;
    m_keep_insert     = '0;
    m_byte_insert_cnt = '0;
    case (state)
      HDR: begin
        m_valid_insert           = s_valid_insert[grant_id];
        s_ready_insert[grant_id] = m_ready_insert;
        if (m_valid_insert) begin
          m_data_insert     = s_data_insert[int'(grant_id) * DATA_WD +: DATA_WD];
          m_keep_insert     = s_keep_insert[int'(grant_id) * DATA_BYTE_WD +: DATA_BYTE_WD];
          m_byte_insert_cnt = s_byte_insert_cnt[int'(grant_id) * BYTE_CNT_WD +: BYTE_CNT_WD];
        end
      end
      PAY: begin
        m_valid_in           = s_valid_in[grant_id];
        s_ready_in[grant_id] = m_ready_in;
        if (m_valid_in) begin
          m_data_in = s_data_in[int'(grant_id) * DATA_WD +: DATA_WD];
          m_keep_in = s_keep_in[int'(grant_id) * DATA_BYTE_WD +: DATA_BYTE_WD];
          m_last_in = s_last_in[grant_id];
        end
      end
      default: ;
    endcase
  end

  // Sequencer: grant in IDLE, hold through header then payload, release after the last beat.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      pkt_done <= 1'b0;
    end else begin
      pkt_done <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_id <= winner;
            state    <= HDR;
          end
        end
        HDR: begin
          // A retracted header valid simply keeps us waiting here.
          if (hdr_fire) state <= PAY;
        end
        PAY: begin
          if (last_fire) begin
            pkt_done <= 1'b1;
`ifndef AXIS_HDR_ARB_STRICT_PRIO_EN
            rr_ptr   <= next_ptr;
`endif
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_insert_header_arb.sv
// Directed bench for axis_insert_header_arb: reset/idle, single source, fairness,
// backpressure, early payload, single-beat packet and reset in mid-packet.
// Inputs change 1 time unit after the rising edge; outputs are checked mid-cycle.
module tb_axis_insert_header_arb;

  localparam int NS = 4;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int CW = $clog2(BW);
  localparam int SW = $clog2(NS);

  logic              clk = 1'b0;
  logic              rstn;
  logic [NS-1:0]     s_valid_in, s_last_in, s_ready_in;
  logic [NS*DW-1:0]  s_data_in;
  logic [NS*BW-1:0]  s_keep_in;
  logic [NS-1:0]     s_valid_insert, s_ready_insert;
  logic [NS*DW-1:0]  s_data_insert;
  logic [NS*BW-1:0]  s_keep_insert;
  logic [NS*CW-1:0]  s_byte_insert_cnt;
  logic              m_valid_in, m_last_in, m_ready_in;
  logic [DW-1:0]     m_data_in;
  logic [BW-1:0]     m_keep_in;
  logic              m_valid_insert, m_ready_insert;
  logic [DW-1:0]     m_data_insert;
  logic [BW-1:0]     m_keep_insert;
  logic [CW-1:0]     m_byte_insert_cnt;
  logic [SW-1:0]     grant_id;
  logic              busy, pkt_done;

  int checks = 0;
  int errors = 0;
  int hdr_acc = 0;
  int pay_acc = 0;
  int done_cnt = 0;

  axis_insert_header_arb dut (
    .clk(clk), .rstn(rstn),
    .s_valid_in(s_valid_in), .s_data_in(s_data_in), .s_keep_in(s_keep_in),
    .s_last_in(s_last_in), .s_ready_in(s_ready_in),
    .s_valid_insert(s_valid_insert), .s_data_insert(s_data_insert),
    .s_keep_insert(s_keep_insert), .s_byte_insert_cnt(s_byte_insert_cnt),
    .s_ready_insert(s_ready_insert),
    .m_valid_in(m_valid_in), .m_data_in(m_data_in), .m_keep_in(m_keep_in),
    .m_last_in(m_last_in), .m_ready_in(m_ready_in),
    .m_valid_insert(m_valid_insert), .m_data_insert(m_data_insert),
    .m_keep_insert(m_keep_insert), .m_byte_insert_cnt(m_byte_insert_cnt),
    .m_ready_insert(m_ready_insert),
    .grant_id(grant_id), .busy(busy), .pkt_done(pkt_done)
  );

  always #5 clk = ~clk;

  // Count completed handshakes mid-cycle, when the values are what the next edge will sample.
  always @(negedge clk) begin
    if (m_valid_insert && m_ready_insert) hdr_acc++;
    if (m_valid_in && m_ready_in) pay_acc++;
    if (pkt_done) done_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_hdr(input int src, input logic [DW-1:0] d, input logic [CW-1:0] c);
    s_data_insert[src*DW +: DW]     = d;
    s_keep_insert[src*BW +: BW]     = '1;
    s_byte_insert_cnt[src*CW +: CW] = c;
  endtask

  task automatic set_pay(input int src, input logic [DW-1:0] d, input logic last);
    s_data_in[src*DW +: DW] = d;
    s_keep_in[src*BW +: BW] = '1;
    s_last_in[src]          = last;
  endtask

  task automatic clear_src();
    s_valid_in = '0; s_last_in = '0; s_data_in = '0; s_keep_in = '0;
    s_valid_insert = '0; s_data_insert = '0; s_keep_insert = '0; s_byte_insert_cnt = '0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    next(); next();
    #3 rstn = 1'b1;
    next();
  endtask

  int h0, p0, d0;

  initial begin
    clear_src();
    m_ready_in = 1'b1;
    m_ready_insert = 1'b1;
    rstn = 1'b0;

    // ---------------- reset and idle ----------------
    do_reset();
    for (int i = 0; i < 10; i++) begin
      settle();
      check("idle_busy", busy, 0);
      check("idle_rdy", {s_ready_in, s_ready_insert}, 0);
      next();
    end
    check("idle_mvld", {m_valid_in, m_valid_insert}, 0);
    check("idle_grant", grant_id, 0);
    check("idle_done", pkt_done, 0);

    // ---------------- single source 2, 3 beats ----------------
    h0 = hdr_acc; p0 = pay_acc; d0 = done_cnt;
    set_hdr(2, 32'hAABBCCDD, 2'd1);
    s_valid_insert[2] = 1'b1;
    settle();
    check("ss_idle_rdy_ins", s_ready_insert, 0);
    check("ss_idle_mvi", m_valid_insert, 0);
    next();
    check("ss_grant", grant_id, 2);
    check("ss_busy", busy, 1);
    check("ss_mvi", m_valid_insert, 1);
    check("ss_hdr_data", m_data_insert, 32'hAABBCCDD);
    check("ss_hdr_keep", m_keep_insert, 4'hF);
    check("ss_hdr_cnt", m_byte_insert_cnt, 1);
    check("ss_rdy_ins", s_ready_insert, 4'b0100);
    check("ss_hdr_mvin", m_valid_in, 0);
    set_pay(2, 32'h2000_0000, 1'b0);
    s_valid_in[2] = 1'b1;
    settle();
    check("ss_hdr_rdy_in", s_ready_in, 0);
    next();
    s_valid_insert[2] = 1'b0;
    settle();
    check("ss_pay_mvi", m_valid_insert, 0);
    check("ss_pay_mvin", m_valid_in, 1);
    check("ss_pay_d0", m_data_in, 32'h2000_0000);
    check("ss_pay_rdy", s_ready_in, 4'b0100);
    next();
    set_pay(2, 32'h2000_0001, 1'b0);
    settle();
    check("ss_pay_d1", m_data_in, 32'h2000_0001);
    next();
    set_pay(2, 32'h2000_0002, 1'b1);
    settle();
    check("ss_pay_d2", m_data_in, 32'h2000_0002);
    check("ss_pay_last", m_last_in, 1);
    next();
    s_valid_in[2] = 1'b0; s_last_in[2] = 1'b0;
    settle();
    check("ss_done_pulse", pkt_done, 1);
    check("ss_back_idle", busy, 0);
    check("ss_hdr_count", hdr_acc - h0, 1);
    check("ss_pay_count", pay_acc - p0, 3);
    next();
    check("ss_done_once", done_cnt - d0, 1);
    check("ss_done_low", pkt_done, 0);

    // ---------------- fairness, all four sources, 2-beat packets ----------------
    do_reset();
    for (int s = 0; s < NS; s++) begin
      set_hdr(s, 32'h0000_1000 + s, 2'd0);
      set_pay(s, 32'h0000_F000 + s, 1'b0);
    end
    s_valid_insert = 4'hF;
    s_valid_in = 4'hF;
    for (int p = 0; p < 5; p++) begin
      settle();
      check("fair_bubble", busy, 0);
      next();
      check("fair_grant", grant_id, p % NS);
      check("fair_hdr", m_data_insert, 32'h0000_1000 + (p % NS));
      next();
      check("fair_rdy", s_ready_in, 4'b0001 << (p % NS));
      check("fair_last0", m_last_in, 0);
      next();
      s_last_in = 4'hF;
      settle();
      check("fair_last1", m_last_in, 1);
      next();
      s_last_in = 4'h0;
      check("fair_done", pkt_done, 1);
    end
    clear_src();
    next();

    // ---------------- backpressure on source 1, 4 beats ----------------
    p0 = pay_acc;
    set_hdr(1, 32'h1111_1111, 2'd3);
    s_valid_insert[1] = 1'b1;
    next();
    check("bp_grant", grant_id, 1);
    set_pay(1, 32'hB000_0000, 1'b0);
    s_valid_in[1] = 1'b1;
    next();
    s_valid_insert[1] = 1'b0;
    for (int b = 0; b < 4; b++) begin
      set_pay(1, 32'hB000_0000 + b, b == 3);
      if (b > 0) begin
        m_ready_in = 1'b0;
        settle();
        check("bp_stall_rdy", s_ready_in, 0);
        next();
        check("bp_stall_data", m_data_in, 32'hB000_0000 + b);
        check("bp_stall_vld", m_valid_in, 1);
      end
      m_ready_in = 1'b1;
      settle();
      check("bp_go_rdy", s_ready_in, 4'b0010);
      check("bp_go_data", m_data_in, 32'hB000_0000 + b);
      next();
    end
    clear_src();
    settle();
    check("bp_done", pkt_done, 1);
    check("bp_beats", pay_acc - p0, 4);
    next();

    // ---------------- early payload on source 3, single beat ----------------
    p0 = pay_acc;
    set_pay(3, 32'h3333_0000, 1'b1);
    s_valid_in[3] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      check("ep_hold_rdy", s_ready_in, 0);
      check("ep_hold_vld", m_valid_in, 0);
      next();
    end
    set_hdr(3, 32'h3333_3333, 2'd2);
    s_valid_insert[3] = 1'b1;
    next();
    check("ep_grant", grant_id, 3);
    check("ep_hdr_rdy_in", s_ready_in, 0);
    next();
    s_valid_insert[3] = 1'b0;
    settle();
    check("ep_pay_rdy", s_ready_in, 4'b1000);
    check("ep_pay_data", m_data_in, 32'h3333_0000);
    check("ep_pay_last", m_last_in, 1);
    next();
    clear_src();
    settle();
    check("ep_done", pkt_done, 1);
    check("ep_beats", pay_acc - p0, 1);
    check("ep_idle", busy, 0);
    next();

    // ---------------- reset during beat 2 of 4 from source 2 ----------------
    set_hdr(2, 32'h2222_2222, 2'd1);
    s_valid_insert[2] = 1'b1;
    next();
    check("rm_grant", grant_id, 2);
    set_pay(2, 32'hC000_0000, 1'b0);
    s_valid_in[2] = 1'b1;
    next();
    s_valid_insert[2] = 1'b0;
    next();
    set_pay(2, 32'hC000_0001, 1'b0);
    settle();
    check("rm_beat2_vld", m_valid_in, 1);
    #2 rstn = 1'b0;
    #1;
    check("rm_busy", busy, 0);
    check("rm_grant_rst", grant_id, 0);
    check("rm_mvld", {m_valid_in, m_valid_insert}, 0);
    check("rm_rdy", {s_ready_in, s_ready_insert}, 0);
    check("rm_mdata", m_data_in, 0);
    clear_src();
    next();
    #3 rstn = 1'b1;
    next();
    s_valid_insert = 4'b1010;
    set_hdr(1, 32'h0101_0101, 2'd0);
    set_hdr(3, 32'h0303_0303, 2'd0);
    next();
    check("rm_after_grant", grant_id, 1);
    check("rm_after_busy", busy, 1);
    clear_src();
    rstn = 1'b0;
    next();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends on its own.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete (observed timeout, expected completion)");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/axis_insert_header_arb.md
# axis_insert_header_arb

Round-robin arbiter and sequencer that shares one `axi_stream_insert_header` instance between NUM_SRC packet sources. Each source presents a header on its own insert channel and a payload on its own stream channel. The arbiter grants one source at a time and routes that source's header, then its payload, to the shared inserter. The grant is held until the payload `last` beat has been accepted. The block sits directly upstream of the inserter and contains no data storage; only control is registered.

## Interface
Parameters:
- `NUM_SRC`, 4 — number of requesting sources (≥2).
- `DATA_WD`, 32 — data width in bits.
- `DATA_BYTE_WD`, `DATA_WD/8` — keep width.
- `BYTE_CNT_WD`, `$clog2(DATA_BYTE_WD)` — width of the header byte count.
- `SRC_WD`, `$clog2(NUM_SRC)` — width of the grant index.

Ports:
- `clk` in 1 — single clock.
- `rstn` in 1 — asynchronous, active-low reset.
- `s_valid_in`/`s_last_in`/`s_ready_in` in/in/out NUM_SRC — per-source payload handshake.
- `s_data_in` in NUM_SRC*DATA_WD — payloads; source i occupies slice [i*DATA_WD +: DATA_WD].
- `s_keep_in` in NUM_SRC*DATA_BYTE_WD — payload keep, packed the same way.
- `s_valid_insert`/`s_ready_insert` in/out NUM_SRC — per-source header handshake.
- `s_data_insert` in NUM_SRC*DATA_WD — headers.
- `s_keep_insert` in NUM_SRC*DATA_BYTE_WD — header keep.
- `s_byte_insert_cnt` in NUM_SRC*BYTE_CNT_WD — header byte counts.
- `m_valid_in`, `m_data_in`, `m_keep_in`, `m_last_in` out 1/DATA_WD/DATA_BYTE_WD/1 — payload channel to the inserter.
- `m_ready_in` in 1 — inserter payload ready.
- `m_valid_insert`, `m_data_insert`, `m_keep_insert`, `m_byte_insert_cnt` out — header channel to the inserter.
- `m_ready_insert` in 1 — inserter header ready.
- `grant_id` out SRC_WD — currently granted source (registered).
- `busy` out 1 — 1 in HDR or PAY.
- `pkt_done` out 1 — one-cycle pulse when the granted packet's `last` beat is accepted.

## Operation
- State machine: IDLE, HDR, PAY.
- **IDLE:**
  - All `s_ready_*` are 0. All `m_valid_*` are 0.
  - If any `s_valid_insert[i]` is 1, the winner is the first requester at or after `rr_ptr` (wrapping modulo NUM_SRC).
  - On the winning edge: `grant_id` ← winner, state → HDR.
- **HDR:**
  - The granted source's insert channel is routed to `m_*_insert`: `m_valid_insert=s_valid_insert[g]` and `s_ready_insert[g]=m_ready_insert`.
  - All other `s_ready_insert` are 0. All `s_ready_in` are 0. `m_valid_in` is 0.
  - On `m_valid_insert && m_ready_insert`: state → PAY.
- **PAY:**
  - The granted source's payload channel is routed to `m_*_in`, with `s_ready_in[g]=m_ready_in`.
  - `m_valid_insert` is 0. All `s_ready_insert` are 0.
  - On `m_valid_in && m_ready_in && m_last_in`: `pkt_done` pulses next cycle, `rr_ptr` ← (g+1) mod NUM_SRC, state → IDLE.
- The `m_*` outputs are combinational muxes of the granted slice. Unselected `m_data`/`m_keep` are driven 0 when the corresponding valid is 0.
- Payload beats that a source presents before its header is accepted are held back, because `s_ready_in` stays 0.
- A source may not retract `s_valid_insert` in HDR (AXI rule). If it does anyway, the arbiter stays in HDR; it never times out.
- `rr_ptr` advances only on packet completion, never on grant.

## Timing
- Reset values: state=IDLE, `rr_ptr`=0, `grant_id`=0, `busy`=0, `pkt_done`=0. All `m_valid_*` and `s_ready_*` are 0.
- Asserting reset mid-packet aborts to IDLE immediately. Both channels drop their valid and ready in the same cycle; no partial-packet flush is performed.
- Grant latency: a request seen in IDLE at edge N gives HDR and `grant_id` valid from cycle N+1. The header handshake is possible from cycle N+1.
- Header-to-payload: the header is accepted at edge M, and payload beats can transfer from cycle M+1.
- Packet turnaround: `last` is accepted at edge L, giving IDLE at L+1 and the next grant at L+2. This is one bubble cycle per packet, so the minimum packet is 3 cycles including the header.
- Single-beat packet (`last` on the first beat): HDR → PAY → IDLE, with one payload transfer.
- Simultaneous requests from all sources: the winner is at `rr_ptr`. Across 4 back-to-back packets, each source is served once.

## Configuration
- `AXIS_HDR_ARB_STRICT_PRIO_EN`:
  - Defined: the IDLE winner is the lowest-index requester, and `rr_ptr` is unused (held 0).
  - Undefined (default): round-robin as described above.

## Test plan
- **Reset and idle:**
  - Stimulus: reset; no requests for 10 cycles.
  - Required: all readys and valids 0, `busy`=0, `grant_id`=0.
- **Single source:**
  - Stimulus: source 2 sends header 0xAABBCCDD with `byte_insert_cnt`=1, then a 3-beat payload.
  - Required: `grant_id`=2 one cycle after the request; exactly 1 header and 3 payload beats forwarded; `pkt_done` pulses once; back in IDLE.
- **Fairness:**
  - Stimulus: all 4 sources request continuously with 2-beat packets.
  - Required: grant order 0,1,2,3,0; one idle cycle between packets.
- **Backpressure:**
  - Stimulus: `m_ready_in` toggles 1,0,1,0 during a 4-beat payload from source 1.
  - Required: data is stable while stalled; source 1 sees `s_ready_in` track `m_ready_in`; other sources' readys stay 0.
- **Early payload:**
  - Stimulus: source 3 raises `s_valid_in` 5 cycles before `s_valid_insert`.
  - Required: `s_ready_in[3]`=0 until the header is accepted; the first payload beat transfers in the cycle after the header handshake.
- **Reset mid-packet:**
  - Stimulus: assert `rstn`=0 during beat 2 of 4.
  - Required: immediate IDLE with outputs at reset values. With `AXIS_HDR_ARB_STRICT_PRIO_EN` defined, the later simultaneous requests from 1 and 3 grant source 1 first.
